// File: rtl/proc_pkg.sv
// Shared types for the 128-bit pipeline's MEM stage.
//   DATA_W / REG_ADDR_W : datapath and register-index widths
//   RESULT_SRC_*        : ResultSrc encodings carried to writeback
//   mem_state_t         : MEM stage access FSM states
//   memwb_t / MEMWB_W   : MEM/WB pipeline register payload and its flat width
package proc_pkg;

   localparam int DATA_W     = 128;
   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] RESULT_SRC_MEM = 2'b00;
   localparam logic [1:0] RESULT_SRC_ALU = 2'b01;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  regwrite;
      logic [1:0]            resultsrc;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     read_data;
   } memwb_t;

   localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst : stage clock, synchronous active-high reset
//   bubble   : load an all-zero payload instead of d
//   d        : next payload (flattened memwb_t)
//   q        : registered payload
module mem_wb_reg
   import proc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               bubble,
   input  logic [MEMWB_W-1:0] d,
   output logic [MEMWB_W-1:0] q
);

   logic [MEMWB_W-1:0] payload_q, payload_d;

   always_comb begin
      payload_d = bubble ? '0 : d;
   end

   always_ff @(posedge clk) begin
      if (rst) payload_q <= '0;
      else     payload_q <= payload_d;
   end

   assign q = payload_q;

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: issues 128-bit loads/stores over a req/ready handshake, stalls
// EX/MEM while an access is outstanding, and owns the MEM/WB register.
//   clk, rst               : stage clock, synchronous active-high reset
//   validM .. WriteDataM   : EX/MEM contents
//   stallM                 : EX/MEM must hold its contents this cycle
//   mem_req/we/addr/wdata  : data-memory request, held stable while BUSY
//   mem_ready, mem_rdata   : completion strobe and load data
//   validW .. ReadDataW    : MEM/WB register outputs to writeback
//   err_misalign/timeout   : sticky error flags, cleared only by rst
module memory_cycle
   import proc_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  validM,
   input  logic                  RegWriteM,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic [4:0]            RdM,
   input  logic [127:0]          ALU_ResultM,
   input  logic [127:0]          WriteDataM,
   output logic                  stallM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [127:0]          mem_wdata,
   input  logic                  mem_ready,
   input  logic [127:0]          mem_rdata,
   output logic                  validW,
   output logic                  RegWriteW,
   output logic [1:0]            ResultSrcW,
   output logic [4:0]            RdW,
   output logic [127:0]          ALU_ResultW,
   output logic [127:0]          ReadDataW,
   output logic                  err_misalign,
   output logic                  err_timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   mem_state_t                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]         req_addr_q, req_addr_d;
   logic [DATA_W-1:0]         req_wdata_q, req_wdata_d;
   logic                      req_we_q, req_we_d;
   logic [REG_ADDR_W-1:0]     req_rd_q, req_rd_d;
   logic                      req_regwrite_q, req_regwrite_d;
   logic [1:0]                req_resultsrc_q, req_resultsrc_d;
   logic [DATA_W-1:0]         req_alu_q, req_alu_d;
   logic                      err_mis_q, err_mis_d;
   logic                      err_to_q, err_to_d;

   logic   memop, mis, timeout_hit, wb_bubble;
   memwb_t wb_d, wb_q;

   assign memop = validM & (MemReadM | MemWriteM);
   assign mis   = memop & (ALU_ResultM[3:0] != 4'h0);

   // Fires on the last permitted BUSY cycle only if the memory is still silent;
   // a same-cycle mem_ready takes priority.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      req_addr_d      = req_addr_q;
      req_wdata_d     = req_wdata_q;
      req_we_d        = req_we_q;
      req_rd_d        = req_rd_q;
      req_regwrite_d  = req_regwrite_q;
      req_resultsrc_d = req_resultsrc_q;
      req_alu_d       = req_alu_q;
      err_mis_d       = err_mis_q;
      err_to_d        = err_to_q;
      stallM          = 1'b0;
      wb_bubble       = 1'b1;
      wb_d            = '0;

      case (state_q)
         MEM_IDLE: begin
            if (mis) begin
               // dropped: stallM stays low so EX/MEM moves on
               err_mis_d = 1'b1;
            end else if (memop) begin
               stallM          = 1'b1;
               state_d         = MEM_BUSY;
               cnt_d           = '0;
               req_addr_d      = {ALU_ResultM[ADDR_W-1:4], 4'h0};
               req_wdata_d     = WriteDataM;
               req_we_d        = MemWriteM;   // read+write together is a store
               req_rd_d        = RdM;
               req_regwrite_d  = RegWriteM;
               req_resultsrc_d = ResultSrcM;
               req_alu_d       = ALU_ResultM;
            end else begin
               wb_bubble       = 1'b0;
               wb_d.valid      = validM;
               wb_d.regwrite   = RegWriteM & validM;
               wb_d.resultsrc  = ResultSrcM;
               wb_d.rd         = RdM;
               wb_d.alu_result = ALU_ResultM;
            end
         end
         MEM_BUSY: begin
            if (mem_ready) begin
               wb_bubble       = 1'b0;
               wb_d.valid      = 1'b1;
               wb_d.regwrite   = req_regwrite_q & !req_we_q;
               wb_d.resultsrc  = req_resultsrc_q;
               wb_d.rd         = req_rd_q;
               wb_d.alu_result = req_alu_q;
               wb_d.read_data  = req_we_q ? '0 : mem_rdata;
               state_d         = MEM_IDLE;
               cnt_d           = '0;
            end else if (timeout_hit) begin
               err_to_d = 1'b1;
               state_d  = MEM_IDLE;
               cnt_d    = '0;
            end else begin
               stallM = 1'b1;
               cnt_d  = cnt_q + 1'b1;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= MEM_IDLE;
         cnt_q           <= '0;
         req_addr_q      <= '0;
         req_wdata_q     <= '0;
         req_we_q        <= 1'b0;
         req_rd_q        <= '0;
         req_regwrite_q  <= 1'b0;
         req_resultsrc_q <= '0;
         req_alu_q       <= '0;
         err_mis_q       <= 1'b0;
         err_to_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         req_addr_q      <= req_addr_d;
         req_wdata_q     <= req_wdata_d;
         req_we_q        <= req_we_d;
         req_rd_q        <= req_rd_d;
         req_regwrite_q  <= req_regwrite_d;
         req_resultsrc_q <= req_resultsrc_d;
         req_alu_q       <= req_alu_d;
         err_mis_q       <= err_mis_d;
         err_to_q        <= err_to_d;
      end
   end

   // Request is a pure function of the registered state, so it can never
   // rise in IDLE and drops the cycle after completion/abort.
   assign mem_req      = (state_q == MEM_BUSY);
   assign mem_we       = req_we_q;
   assign mem_addr     = req_addr_q;
   assign mem_wdata    = req_wdata_q;
   assign err_misalign = err_mis_q;
   assign err_timeout  = err_to_q;

   mem_wb_reg u_mem_wb (
      .clk    (clk),
      .rst    (rst),
      .bubble (wb_bubble),
      .d      (wb_d),
      .q      (wb_q)
   );

   assign validW      = wb_q.valid;
   assign RegWriteW   = wb_q.regwrite;
   assign ResultSrcW  = wb_q.resultsrc;
   assign RdW         = wb_q.rd;
   assign ALU_ResultW = wb_q.alu_result;
   assign ReadDataW   = wb_q.read_data;

endmodule
